// File: rtl/ysyx_23060332_lsu_pkg.sv
// Shared LSU definitions: FSM states, load/store func3 codes, strobe constants
// and bus widths used by the LSU, its alignment helper and the bus interface.
package ysyx_23060332_lsu_pkg;

    localparam int unsigned REG_DATA_W = 32;  // RegDataBus
    localparam int unsigned REG_ADDR_W = 5;   // RegAddrBus
    localparam int unsigned MEM_ADDR_W = 32;  // MemAddrBus

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] INST_LB  = 3'b000;
    localparam logic [2:0] INST_LH  = 3'b001;
    localparam logic [2:0] INST_LW  = 3'b010;
    localparam logic [2:0] INST_LBU = 3'b100;
    localparam logic [2:0] INST_LHU = 3'b101;
    localparam logic [2:0] INST_SB  = 3'b000;
    localparam logic [2:0] INST_SH  = 3'b001;
    localparam logic [2:0] INST_SW  = 3'b010;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_H    = 4'b0011;
    localparam logic [3:0] STRB_W    = 4'b1111;

endpackage

// File: rtl/ysyx_23060332_lsu_if.sv
// Split request/response memory bus between the LSU (master) and memory (slave).
interface ysyx_23060332_lsu_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_23060332_lsu_align.sv
// Combinational alignment helper: legality/misalignment check, store lane
// replication with strobes, and load byte/half extraction with extension.
module ysyx_23060332_lsu_align
    import ysyx_23060332_lsu_pkg::*;
(
    input  logic        ren,
    input  logic        wen,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        err,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] ld_data
);

    logic        illegal;
    logic        misalign;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        if (ren && wen) begin
            illegal = 1'b1;
        end else if (ren) begin
            illegal = !(func3 inside {INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU});
        end else if (wen) begin
            illegal = !(func3 inside {INST_SB, INST_SH, INST_SW});
        end
        // func3[1:0] encodes access size for every legal load and store
        case (func3[1:0])
            2'b01:   misalign = addr_lo[0];
            2'b10:   misalign = (addr_lo != 2'b00);
            default: misalign = 1'b0;
        endcase
        err = (ren || wen) && (illegal || misalign);
    end

    always_comb begin
        case (func3[1:0])
            2'b00: begin
                st_wdata = {4{wdata[7:0]}};
                st_wstrb = STRB_B << addr_lo;
            end
            2'b01: begin
                st_wdata = {2{wdata[15:0]}};
                st_wstrb = STRB_H << {addr_lo[1], 1'b0};
            end
            default: begin
                st_wdata = wdata;
                st_wstrb = STRB_W;
            end
        endcase
    end

    always_comb begin
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (func3)
            INST_LB:  ld_data = {{24{byte_v[7]}}, byte_v};
            INST_LBU: ld_data = {24'h0, byte_v};
            INST_LH:  ld_data = {{16{half_v[15]}}, half_v};
            INST_LHU: ld_data = {16'h0, half_v};
            default:  ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: accepts one EXU op, performs at most one bus access, and
// holds the aligned writeback result until the register-file stage takes it.
module ysyx_23060332_lsu
    import ysyx_23060332_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_ren,
    input  logic              in_wen,
    input  logic [2:0]        in_func3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [4:0]        in_waddr,
    input  logic              in_reg_wen,
    ysyx_23060332_lsu_if.master bus,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_waddr,
    output logic [DATA_W-1:0] out_wdata,
    output logic              out_reg_wen,
    output logic              out_err
);

    lsu_state_e  state;
    logic        lat_wen;
    logic [2:0]  lat_func3;
    logic [1:0]  lat_addr_lo;
    logic        lat_reg_wen;

    logic [2:0]  a_func3;
    logic [1:0]  a_addr_lo;
    logic        a_err;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;

    // One helper serves both the accept-time checks (live inputs) and the
    // response-time extraction (latched size/offset).
    assign a_func3   = (state == LSU_IDLE) ? in_func3     : lat_func3;
    assign a_addr_lo = (state == LSU_IDLE) ? in_addr[1:0] : lat_addr_lo;

    ysyx_23060332_lsu_align u_align (
        .ren      (in_ren),
        .wen      (in_wen),
        .func3    (a_func3),
        .addr_lo  (a_addr_lo),
        .wdata    (in_wdata),
        .rdata    (bus.rsp_rdata),
        .err      (a_err),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LSU_IDLE;
            in_ready      <= 1'b1;
            lat_wen       <= 1'b0;
            lat_func3     <= '0;
            lat_addr_lo   <= '0;
            lat_reg_wen   <= 1'b0;
            bus.req_valid <= 1'b0;
            bus.req_wen   <= 1'b0;
            bus.req_addr  <= '0;
            bus.req_wdata <= '0;
            bus.req_wstrb <= '0;
            out_valid     <= 1'b0;
            out_waddr     <= '0;
            out_wdata     <= '0;
            out_reg_wen   <= 1'b0;
            out_err       <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (in_valid) begin
                        lat_wen     <= in_wen;
                        lat_func3   <= in_func3;
                        lat_addr_lo <= in_addr[1:0];
                        lat_reg_wen <= in_reg_wen;
                        in_ready    <= 1'b0;
                        out_waddr   <= in_waddr;
                        if (!in_ren && !in_wen) begin
                            state       <= LSU_DONE;
                            out_valid   <= 1'b1;
                            out_wdata   <= in_alu_res;
                            out_reg_wen <= in_reg_wen;
                            out_err     <= 1'b0;
                        end else if (a_err) begin
                            state       <= LSU_DONE;
                            out_valid   <= 1'b1;
                            out_wdata   <= '0;
                            out_reg_wen <= 1'b0;
                            out_err     <= 1'b1;
                        end else begin
                            state         <= LSU_REQ;
                            bus.req_valid <= 1'b1;
                            bus.req_wen   <= in_wen;
                            bus.req_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
                            bus.req_wdata <= in_wen ? st_wdata : '0;
                            bus.req_wstrb <= in_wen ? st_wstrb : STRB_NONE;
                        end
                    end
                end
                LSU_REQ: begin
                    if (bus.req_ready) begin
                        state         <= LSU_WAIT;
                        bus.req_valid <= 1'b0;
                    end
                end
                LSU_WAIT: begin
                    if (bus.rsp_valid) begin
                        state     <= LSU_DONE;
                        out_valid <= 1'b1;
                        if (bus.rsp_err) begin
                            out_wdata   <= '0;
                            out_reg_wen <= 1'b0;
                            out_err     <= 1'b1;
                        end else begin
                            out_wdata   <= lat_wen ? '0 : ld_data;
                            out_reg_wen <= lat_reg_wen;
                            out_err     <= 1'b0;
                        end
                    end
                end
                LSU_DONE: begin
                    if (out_ready) begin
                        state     <= LSU_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Scoreboard bench for the LSU: drivers queue expected bus requests and
// writebacks, a negedge monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_ysyx_23060332_lsu;
    import ysyx_23060332_lsu_pkg::*;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        reg_wen;
        logic        err;
    } out_t;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_ren, in_wen, in_reg_wen;
    logic [2:0]  in_func3;
    logic [31:0] in_addr, in_wdata, in_alu_res;
    logic [4:0]  in_waddr;
    logic        out_valid, out_ready, out_reg_wen, out_err;
    logic [4:0]  out_waddr;
    logic [31:0] out_wdata;

    ysyx_23060332_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ysyx_23060332_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ren      (in_ren),
        .in_wen      (in_wen),
        .in_func3    (in_func3),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_alu_res  (in_alu_res),
        .in_waddr    (in_waddr),
        .in_reg_wen  (in_reg_wen),
        .bus         (bus),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_waddr   (out_waddr),
        .out_wdata   (out_wdata),
        .out_reg_wen (out_reg_wen),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    out_t out_q[$];
    req_t req_q[$];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic out_t mk_out(input logic [4:0] wa, input logic [31:0] wd, input logic rw, input logic er);
        out_t o;
        o.waddr = wa; o.wdata = wd; o.reg_wen = rw; o.err = er;
        return o;
    endfunction

    function automatic req_t mk_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_t r;
        r.wen = w; r.addr = a; r.wdata = d; r.wstrb = s;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req_valid && bus.req_ready) begin
                if (req_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL req_unexpected: got addr %h with no request expected", bus.req_addr);
                end else begin
                    req_t e;
                    e = req_q.pop_front();
                    check("req", {bus.req_wen, bus.req_addr, bus.req_wdata, bus.req_wstrb}, e);
                end
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL out_unexpected: got wdata %h with no writeback expected", out_wdata);
                end else begin
                    out_t e;
                    e = out_q.pop_front();
                    check("out", {out_waddr, out_wdata, out_reg_wen, out_err}, e);
                end
            end
        end
    end

    task automatic run_op(input string nm, input logic ren, input logic wen, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] alu,
                          input logic [4:0] wa, input logic rw, input logic [31:0] rdata, input logic rerr,
                          input int req_stall, input int out_stall, input int exp_lat,
                          input out_t exp_out, input logic has_req, input req_t exp_req);
        int   guard;
        int   stall;
        logic pend, busy_ok, req_stable, snapped, out_stable;
        req_t snap;
        out_t osnap;
        if (has_req) req_q.push_back(exp_req);
        out_q.push_back(exp_out);
        out_ready = (out_stall == 0);
        check({nm, "_in_ready_idle"}, in_ready, 1);
        in_valid = 1; in_ren = ren; in_wen = wen; in_func3 = f3; in_addr = addr;
        in_wdata = wd; in_alu_res = alu; in_waddr = wa; in_reg_wen = rw;
        @(posedge clk); #1;
        in_valid = 0; in_ren = 0; in_wen = 0; in_func3 = 3'b111; in_addr = '0;
        in_wdata = '0; in_alu_res = '0; in_waddr = '0; in_reg_wen = 0;
        check({nm, "_req_valid"}, bus.req_valid, has_req);
        guard = 0; stall = req_stall; pend = 0; busy_ok = 1; req_stable = 1; snapped = 0;
        while (!out_valid && guard < 50) begin
            if (in_ready !== 1'b0) busy_ok = 0;
            bus.rsp_valid = 0;
            if (pend) begin
                bus.rsp_valid = 1; bus.rsp_rdata = rdata; bus.rsp_err = rerr; pend = 0;
            end
            if (bus.req_valid) begin
                if (!snapped) begin
                    snap = {bus.req_wen, bus.req_addr, bus.req_wdata, bus.req_wstrb};
                    snapped = 1;
                end else if ({bus.req_wen, bus.req_addr, bus.req_wdata, bus.req_wstrb} !== snap) begin
                    req_stable = 0;
                end
                if (stall > 0) begin
                    bus.req_ready = 0; stall--;
                end else begin
                    bus.req_ready = 1; pend = 1;
                end
            end else begin
                bus.req_ready = 0;
            end
            @(posedge clk); #1;
            guard++;
        end
        bus.rsp_valid = 0; bus.req_ready = 0; bus.rsp_err = 0;
        check({nm, "_latency"}, guard, exp_lat);
        if (req_stall > 0) check({nm, "_req_stable"}, req_stable, 1);
        osnap = {out_waddr, out_wdata, out_reg_wen, out_err};
        out_stable = 1;
        for (int i = 0; i < out_stall; i++) begin
            if ({out_waddr, out_wdata, out_reg_wen, out_err} !== osnap || out_valid !== 1'b1 || in_ready !== 1'b0)
                out_stable = 0;
            @(posedge clk); #1;
        end
        if (out_stall > 0) check({nm, "_out_stable"}, out_stable, 1);
        if (out_valid !== 1'b1 || in_ready !== 1'b0) busy_ok = 0;
        check({nm, "_busy"}, busy_ok, 1);
        out_ready = 1;
        @(posedge clk); #1;
        check({nm, "_released"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        rst = 0; in_valid = 0; in_ren = 0; in_wen = 0; in_func3 = 0; in_addr = 0;
        in_wdata = 0; in_alu_res = 0; in_waddr = 0; in_reg_wen = 0; out_ready = 1;
        bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_rdata = 0; bus.rsp_err = 0;
        #2 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("reset_ctrl", {in_ready, bus.req_valid, out_valid}, 3'b100);
        check("reset_out", {out_waddr, out_wdata, out_reg_wen, out_err}, '0);

        run_op("pass", 0, 0, 3'b000, 32'h0, 32'h0, 32'h12345678, 5'd5, 1, 32'h0, 0, 0, 0, 0,
               mk_out(5'd5, 32'h12345678, 1, 0), 0, mk_req(0, 0, 0, 0));
        run_op("lb", 1, 0, INST_LB, 32'h80000003, 0, 0, 5'd6, 1, 32'h80FF0011, 0, 0, 0, 2,
               mk_out(5'd6, 32'hFFFFFF80, 1, 0), 1, mk_req(0, 32'h80000000, 0, 4'b0000));
        run_op("lbu", 1, 0, INST_LBU, 32'h80000003, 0, 0, 5'd6, 1, 32'h80FF0011, 0, 0, 0, 2,
               mk_out(5'd6, 32'h00000080, 1, 0), 1, mk_req(0, 32'h80000000, 0, 4'b0000));
        run_op("lb0", 1, 0, INST_LB, 32'h80000000, 0, 0, 5'd4, 1, 32'h80FF0011, 0, 0, 0, 2,
               mk_out(5'd4, 32'h00000011, 1, 0), 1, mk_req(0, 32'h80000000, 0, 4'b0000));
        run_op("lh", 1, 0, INST_LH, 32'h80000002, 0, 0, 5'd11, 1, 32'h80011234, 0, 0, 0, 2,
               mk_out(5'd11, 32'hFFFF8001, 1, 0), 1, mk_req(0, 32'h80000000, 0, 4'b0000));
        run_op("lhu", 1, 0, INST_LHU, 32'h80000000, 0, 0, 5'd12, 1, 32'h8001F234, 0, 0, 0, 2,
               mk_out(5'd12, 32'h0000F234, 1, 0), 1, mk_req(0, 32'h80000000, 0, 4'b0000));
        run_op("sh", 0, 1, INST_SH, 32'h80000102, 32'hAAAABEEF, 0, 5'd0, 0, 32'h0, 0, 0, 0, 2,
               mk_out(5'd0, 32'h0, 0, 0), 1, mk_req(1, 32'h80000100, 32'hBEEFBEEF, 4'b1100));
        run_op("sb", 0, 1, INST_SB, 32'h80000001, 32'h000000A5, 0, 5'd0, 0, 32'h0, 0, 0, 0, 2,
               mk_out(5'd0, 32'h0, 0, 0), 1, mk_req(1, 32'h80000000, 32'hA5A5A5A5, 4'b0010));
        run_op("sw_rw", 0, 1, INST_SW, 32'h80000008, 32'h01020304, 0, 5'd3, 1, 32'h0, 0, 0, 0, 2,
               mk_out(5'd3, 32'h0, 1, 0), 1, mk_req(1, 32'h80000008, 32'h01020304, 4'b1111));
        run_op("lw_mis", 1, 0, INST_LW, 32'h80000001, 0, 0, 5'd7, 1, 32'h0, 0, 0, 0, 0,
               mk_out(5'd7, 32'h0, 0, 1), 0, mk_req(0, 0, 0, 0));
        run_op("lh_mis", 1, 0, INST_LH, 32'h80000003, 0, 0, 5'd7, 1, 32'h0, 0, 0, 0, 0,
               mk_out(5'd7, 32'h0, 0, 1), 0, mk_req(0, 0, 0, 0));
        run_op("sw_mis", 0, 1, INST_SW, 32'h80000002, 32'h11111111, 0, 5'd0, 0, 32'h0, 0, 0, 0, 0,
               mk_out(5'd0, 32'h0, 0, 1), 0, mk_req(0, 0, 0, 0));
        run_op("ld_ill", 1, 0, 3'b011, 32'h80000000, 0, 0, 5'd8, 1, 32'h0, 0, 0, 0, 0,
               mk_out(5'd8, 32'h0, 0, 1), 0, mk_req(0, 0, 0, 0));
        run_op("st_ill", 0, 1, 3'b100, 32'h80000000, 32'h22222222, 0, 5'd0, 0, 32'h0, 0, 0, 0, 0,
               mk_out(5'd0, 32'h0, 0, 1), 0, mk_req(0, 0, 0, 0));
        run_op("rw_ill", 1, 1, INST_LW, 32'h80000000, 0, 0, 5'd8, 1, 32'h0, 0, 0, 0, 0,
               mk_out(5'd8, 32'h0, 0, 1), 0, mk_req(0, 0, 0, 0));
        run_op("lw_bp", 1, 0, INST_LW, 32'h80000004, 0, 0, 5'd10, 1, 32'hDEADBEEF, 0, 3, 2, 5,
               mk_out(5'd10, 32'hDEADBEEF, 1, 0), 1, mk_req(0, 32'h80000004, 0, 4'b0000));
        run_op("lw_err", 1, 0, INST_LW, 32'h8000000C, 0, 0, 5'd9, 1, 32'h12345678, 1, 0, 0, 2,
               mk_out(5'd9, 32'h0, 0, 1), 1, mk_req(0, 32'h8000000C, 0, 4'b0000));

        // Reset while the request is pending in REQ
        out_ready = 1;
        in_valid = 1; in_ren = 1; in_wen = 0; in_func3 = INST_LW; in_addr = 32'h80000010;
        @(posedge clk); #1;
        in_valid = 0; in_ren = 0;
        check("rst_req_pre", bus.req_valid, 1);
        rst = 1; #1;
        check("rst_req_now", {bus.req_valid, out_valid, in_ready}, 3'b001);
        #2 rst = 0;
        @(posedge clk); #1;

        // Reset while waiting for the response, then a stale response arrives
        req_q.push_back(mk_req(0, 32'h80000010, 0, 4'b0000));
        in_valid = 1; in_ren = 1; in_func3 = INST_LW; in_addr = 32'h80000010; in_waddr = 5'd13; in_reg_wen = 1;
        @(posedge clk); #1;
        in_valid = 0; in_ren = 0;
        bus.req_ready = 1;
        @(posedge clk); #1;
        bus.req_ready = 0;
        rst = 1; #1;
        check("rst_wait_now", {bus.req_valid, out_valid, in_ready}, 3'b001);
        #2 rst = 0;
        bus.rsp_valid = 1; bus.rsp_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.rsp_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wait_stale", {bus.req_valid, out_valid, in_ready}, 3'b001);

        // Reset while holding a result in DONE
        out_ready = 0;
        in_valid = 1; in_alu_res = 32'h55AA55AA; in_waddr = 5'd2;
        @(posedge clk); #1;
        in_valid = 0;
        check("rst_done_pre", out_valid, 1);
        rst = 1; #1;
        check("rst_done_now", {bus.req_valid, out_valid, in_ready, out_wdata}, {3'b001, 32'h0});
        #2 rst = 0;
        out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("queues_empty", req_q.size() + out_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
